da_accum_param: RTL

DA_ACCUM_PARAM -- requirements
Module: da_accum_param

---
 rtl/da_accum_param_pkg.sv | 24 ++
 rtl/da_adder_tree.sv | 23 ++
 rtl/da_accum_param.sv | 112 +++++++++++
 3 files changed

// File: rtl/da_accum_param_pkg.sv
// Shared defaults and helpers for the distributed-arithmetic accumulator.
//   DEF_* : default parameter values used by da_accum_param / da_adder_tree
//   clog2 : ceiling log2, returns 0 for inputs 0 and 1
package da_accum_param_pkg;

    localparam int unsigned DEF_NUM_LUT = 8;
    localparam int unsigned DEF_LUT_W   = 32;
    localparam int unsigned DEF_BITS    = 8;
    localparam int unsigned DEF_ACC_W   = 32;
    localparam int unsigned DEF_SIGNED  = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/da_adder_tree.sv
// Combinational signed sum of NUM_LUT partial products.
//   lut_out : NUM_LUT concatenated two's-complement words, LUT k at [k*LUT_W +: LUT_W]
//   tree_s  : signed sum, wide enough that it never overflows
module da_adder_tree
    import da_accum_param_pkg::*;
#(
    parameter  int unsigned NUM_LUT = DEF_NUM_LUT,
    parameter  int unsigned LUT_W   = DEF_LUT_W,
    localparam int unsigned TREE_W  = LUT_W + clog2(NUM_LUT)
) (
    input  logic [NUM_LUT*LUT_W-1:0] lut_out,
    output logic [TREE_W-1:0]        tree_s
);

    // Each word is sign-extended to the full tree width before summing.
    always_comb begin
        tree_s = '0;
        for (int k = 0; k < int'(NUM_LUT); k++) begin
            tree_s = tree_s + TREE_W'($signed(lut_out[k*LUT_W +: LUT_W]));
        end
    end

endmodule

// File: rtl/da_accum_param.sv
// Bit-serial distributed-arithmetic shift-accumulator, MSB first.
//   clk3      : clock, rising edge
//   reset     : synchronous active-high reset (highest priority)
//   clear     : synchronous frame abort, sum is kept
//   in_valid  : lut_out holds partial products for bit bit_sel
//   lut_out   : NUM_LUT concatenated LUT outputs
//   bit_sel   : sample bit expected next (BITS-1 down to 0)
//   busy      : a frame is partially accumulated
//   sum       : last completed frame result
//   out_valid : one-cycle pulse when sum updates
module da_accum_param
    import da_accum_param_pkg::*;
#(
    parameter  int unsigned NUM_LUT = DEF_NUM_LUT,
    parameter  int unsigned LUT_W   = DEF_LUT_W,
    parameter  int unsigned BITS    = DEF_BITS,
    parameter  int unsigned ACC_W   = DEF_ACC_W,
    parameter  int unsigned SIGNED  = DEF_SIGNED,
    localparam int unsigned CNT_W   = (clog2(BITS) > 0) ? clog2(BITS) : 1,
    localparam int unsigned TREE_W  = LUT_W + clog2(NUM_LUT)
) (
    input  logic                     clk3,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [NUM_LUT*LUT_W-1:0] lut_out,
    output logic [CNT_W-1:0]         bit_sel,
    output logic                     busy,
    output logic [ACC_W-1:0]         sum,
    output logic                     out_valid
);

    localparam logic [CNT_W-1:0] MSB_IDX = CNT_W'(BITS - 1);

    logic [TREE_W-1:0] tree_s;
    logic [ACC_W-1:0]  s_acc;
    logic [ACC_W-1:0]  acc_step;
    logic              first_bit;
    logic              last_bit;

    logic [CNT_W-1:0]  bit_sel_q, bit_sel_d;
    logic [ACC_W-1:0]  acc_q,     acc_d;
    logic [ACC_W-1:0]  sum_q,     sum_d;
    logic              valid_q,   valid_d;
    logic              busy_q,    busy_d;

    da_adder_tree #(
        .NUM_LUT (NUM_LUT),
        .LUT_W   (LUT_W)
    ) u_tree (
        .lut_out (lut_out),
        .tree_s  (tree_s)
    );

    // Size cast sign-extends or truncates the tree sum to the accumulator width.
    assign s_acc = ACC_W'($signed(tree_s));

    // MSB restarts the accumulator; its weight is negative for signed samples.
    always_comb begin
        first_bit = (bit_sel_q == MSB_IDX);
        last_bit  = (bit_sel_q == '0);
        if (first_bit) begin
            acc_step = (SIGNED != 0) ? (ACC_W'(0) - s_acc) : s_acc;
        end else begin
            acc_step = (acc_q << 1) + s_acc;
        end
    end

    // Next-state: clear beats in_valid; stalls hold everything.
    always_comb begin
        bit_sel_d = bit_sel_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        valid_d   = 1'b0;
        if (clear) begin
            bit_sel_d = MSB_IDX;
            acc_d     = '0;
        end else if (in_valid) begin
            acc_d = acc_step;
            if (last_bit) begin
                bit_sel_d = MSB_IDX;
                sum_d     = acc_step;
                valid_d   = 1'b1;
            end else begin
                bit_sel_d = bit_sel_q - CNT_W'(1);
            end
        end
        busy_d = (bit_sel_d != MSB_IDX);
    end

    always_ff @(posedge clk3) begin
        if (reset) begin
            bit_sel_q <= MSB_IDX;
            acc_q     <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            bit_sel_q <= bit_sel_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bit_sel   = bit_sel_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign out_valid = valid_q;

endmodule
